state_to_string: RTL
====================

Name: state_to_string

Overview:
- Inverse of the Keccak bitstring-to-state mapping (FIPS 202 §3.1.3): S[w*(5y+x)+z] = A[x][y][z].
- Accepts one 5x5xW state array per transaction and captures it as a flat B-bit string.
- Streams the first out_len bits of that string as DW-bit chunks over a valid/ready interface.
- Sits after the Keccak-f permutation and feeds the squeeze/digest output path.

Parameters:
- W, 64: lane width, same as `w; legal values 1,2,4,...,64.
- B, 25*W: state width in bits, same as `len_bitstring; derived, not overridden.
- DW, 64: output chunk width; B % DW must be 0.
- LW, $clog2(B+1): width of out_len.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-low reset.
- in_valid  in  1  state array and out_len are valid.
- in_ready  out  1  block can accept a state; high only in IDLE.
- Abc  in  [W-1:0] [4:0][4:0]  state array, Abc[x][y][z].
- out_len  in  LW  number of bits to emit; sampled at accept.
- out_valid  out  1  chunk on out_data is valid.
- out_ready  in  1  sink accepts the chunk.
- out_data  out  DW  chunk; bit j of chunk k = S[k*DW + j].
- out_nbits  out  $clog2(DW+1)  number of valid bits in out_data.
- out_last  out  1  final chunk of the transaction.

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_last=0, out_nbits=0, out_data=0, internal string register=0, chunk index=0, remaining=0.
- FSM states: IDLE and SEND.
  - IDLE: in_ready=1, out_valid=0.
  - SEND: in_ready=0, out_valid=1.
- Accept: in IDLE, in_valid=1 at a rising edge.
  - Flatten Abc into the B-bit register with S[W*(5y+x)+z] = Abc[x][y][z].
  - Load remaining = eff_len; chunk index=0; go to SEND.
  - First chunk is valid in the cycle after the accept edge (latency 1).
- eff_len:
  - out_len==0 → eff_len = B.
  - out_len > B → eff_len = B (clamped).
  - Otherwise eff_len = out_len.
- SEND outputs (all registered):
  - out_data = S[idx*DW +: DW], with bits at positions >= remaining forced to 0.
  - out_nbits = min(remaining, DW).
  - out_last = (remaining <= DW).
- Handshake: transfer when out_valid & out_ready at a rising edge.
  - Not last: idx += 1, remaining -= DW.
  - Last: return to IDLE; in_ready rises in the next cycle.
  - No new accept is possible in the same cycle as the last transfer.
- Stall: while out_valid=1 and out_ready=0, out_data, out_nbits and out_last hold stable; no chunk is dropped or duplicated.
- in_valid during SEND: ignored; Abc and out_len are not sampled.
- Chunk count: ceil(eff_len/DW); maximum B/DW (25 with defaults).
- Reset mid-SEND: outputs return to reset values immediately (asynchronously); the partial transaction is discarded; the next accept starts at chunk 0.
- No combinational path from out_ready or in_valid to any output, except in_ready, which is decoded from state only.

Test Plan:
- Reset: assert reset low mid-cycle → out_valid=0, in_ready=1, out_data=0, out_last=0 without waiting for a clock edge.
- Full state: lane (x,y) = 64'(5y+x), out_len=1600, out_ready=1 → 25 chunks on consecutive cycles, chunk k = 64'(k), out_nbits=64, out_last only on k=24, in_ready=1 on the following cycle.
- SHA3-256 rate: same state, out_len=1088 → 17 chunks with values 0..16, out_last on chunk 16; out_len=0 → 25 chunks, same as the full-state case.
- Partial chunk: lane (x,y) = 64'hFFFF_FFFF_FFFF_FFFF, out_len=200 → 4 chunks; chunk 3 has out_nbits=8, out_data=64'h0000_0000_0000_00FF, out_last=1.
- Backpressure: out_ready pattern 1,0,0,1,0,1,... with in_valid held high and different Abc applied during SEND → exactly ceil(len/DW) transfers in order, data stable during stalls, second state accepted only after the IDLE cycle.
- Reset mid-op: reset pulsed after 3 transfers of a 1600-bit transaction → out_valid drops at once; a new state with lane (x,y) = 64'(100+5y+x) then yields first chunk 64'd100.

Source files
------------

// File: rtl/state_to_string.sv
// Keccak state-array to bitstring converter: captures a 5x5xW state as the flat string
// S[W*(5y+x)+z] = A[x][y][z] and streams its first out_len bits as DW-bit chunks.
module state_to_string #(
  parameter int unsigned W  = 64,
  parameter int unsigned DW = 64,
  localparam int unsigned B  = 25 * W,
  localparam int unsigned LW = $clog2(B + 1),
  localparam int unsigned NW = $clog2(DW + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4:0][4:0][W-1:0] Abc,
  input  logic [LW-1:0]          out_len,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DW-1:0]          out_data,
  output logic [NW-1:0]          out_nbits,
  output logic                   out_last
);

  localparam int unsigned NC = B / DW;
  localparam int unsigned IW = (NC > 1) ? $clog2(NC) : 1;
  localparam logic [LW-1:0] BLen = LW'(B);
  localparam logic [LW-1:0] DLen = LW'(DW);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e          state_q;
  logic [B-1:0]    s_q;
  logic [IW-1:0]   idx_q;
  logic [LW-1:0]   rem_q;
  logic            out_valid_q;
  logic            out_last_q;
  logic [DW-1:0]   out_data_q;
  logic [NW-1:0]   out_nbits_q;

  logic [B-1:0]          flat;
  logic [LW-1:0]         eff_len;
  logic [LW-1:0]         rem_nxt;
  logic [IW-1:0]         idx_nxt;
  logic [NC-1:0][DW-1:0] s_chunks;
  logic [DW-1:0]         chunk_nxt;

  // Clear every bit at or beyond the remaining length.
  function automatic logic [DW-1:0] trim(input logic [DW-1:0] c, input logic [LW-1:0] rem);
    logic [DW-1:0] r;
    r = '0;
    for (int unsigned j = 0; j < DW; j++) begin
      r[j] = c[j] & (j < 32'(rem));
    end
    return r;
  endfunction

  function automatic logic [NW-1:0] nbits(input logic [LW-1:0] rem);
    return (rem >= DLen) ? NW'(DW) : NW'(rem);
  endfunction

  always_comb begin
    flat = '0;
    for (int x = 0; x < 5; x++) begin
      for (int y = 0; y < 5; y++) begin
        flat[W*(5*y+x) +: W] = Abc[x][y];
      end
    end
    // Zero and oversize lengths both mean the whole state.
    if (out_len == '0 || out_len > BLen) begin
      eff_len = BLen;
    end else begin
      eff_len = out_len;
    end
    rem_nxt   = rem_q - DLen;
    idx_nxt   = idx_q + IW'(1);
    s_chunks  = s_q;
    chunk_nxt = s_chunks[idx_nxt];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      s_q         <= '0;
      idx_q       <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_nbits_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            state_q     <= StSend;
            s_q         <= flat;
            idx_q       <= '0;
            rem_q       <= eff_len;
            out_valid_q <= 1'b1;
            out_data_q  <= trim(flat[DW-1:0], eff_len);
            out_nbits_q <= nbits(eff_len);
            out_last_q  <= (eff_len <= DLen);
          end
        end
        StSend: begin
          if (out_ready) begin
            if (out_last_q) begin
              state_q     <= StIdle;
              idx_q       <= '0;
              rem_q       <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_data_q  <= '0;
              out_nbits_q <= '0;
            end else begin
              idx_q       <= idx_nxt;
              rem_q       <= rem_nxt;
              out_data_q  <= trim(chunk_nxt, rem_nxt);
              out_nbits_q <= nbits(rem_nxt);
              out_last_q  <= (rem_nxt <= DLen);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_nbits = out_nbits_q;
  assign out_last  = out_last_q;

endmodule
